// File: rtl/ctrl_seq.sv
// Microprogram sequencer for the 8-bit CPU: one-hot T1..T6 ring with opcode decode
// into the per-cycle control word, free-run / single-step advance and sticky halt.
module ctrl_seq #(
  parameter logic [3:0] OPC_LDA   = 4'h0,
  parameter logic [3:0] OPC_ADD   = 4'h1,
  parameter logic [3:0] OPC_SUB   = 4'h2,
  parameter logic [3:0] OPC_JMP   = 4'h3,
  parameter logic [3:0] OPC_OUT   = 4'hE,
  parameter logic [3:0] OPC_HLT   = 4'hF,
  parameter bit         EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       clr,
  output logic       cp,
  output logic       ep,
  output logic       po,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  typedef struct packed {
    logic cp, ep, po, lm, ce, li, ei, la, ea, lb, su, eu, lo;
  } ctrl_t;

  state_t state;
  state_t next_state;
  logic   hlt_q;
  logic   step_q;
  logic   adv;
  logic   active;
  logic   last;
  ctrl_t  dec;
  ctrl_t  ctrl;

  // A held step counts once: only the 0->1 transition advances.
  assign adv    = run | (step & ~step_q);
  assign active = adv & rst & ~hlt_q;

  always_comb begin
    dec  = '0;
    last = 1'b0;
    case (state)
      T1: begin
        dec.ep = 1'b1;
        dec.lm = 1'b1;
      end
      T2: dec.cp = 1'b1;
      T3: begin
        dec.ce = 1'b1;
        dec.li = 1'b1;
      end
      T4: begin
        if (opcode == OPC_LDA || opcode == OPC_ADD || opcode == OPC_SUB) begin
          dec.ei = 1'b1;
          dec.lm = 1'b1;
        end else begin
          last = EARLY_END;
          if (opcode == OPC_JMP) begin
            dec.ei = 1'b1;
            dec.po = 1'b1;
          end else if (opcode == OPC_OUT) begin
            dec.ea = 1'b1;
            dec.lo = 1'b1;
          end
        end
      end
      T5: begin
        if (opcode == OPC_LDA) begin
          dec.ce = 1'b1;
          dec.la = 1'b1;
          last   = EARLY_END;
        end else if (opcode == OPC_ADD || opcode == OPC_SUB) begin
          dec.ce = 1'b1;
          dec.lb = 1'b1;
          dec.su = (opcode == OPC_SUB);
        end
      end
      T6: begin
        last = 1'b1;
        if (opcode == OPC_ADD || opcode == OPC_SUB) begin
          dec.eu = 1'b1;
          dec.la = 1'b1;
          dec.su = (opcode == OPC_SUB);
        end
      end
      default: last = 1'b1;
    endcase
  end

  assign next_state = last ? T1 : state_t'({state[4:0], 1'b0});
  assign ctrl       = active ? dec : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= T1;
      hlt_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      if (adv && !hlt_q) begin
        if (state == T4 && opcode == OPC_HLT) hlt_q <= 1'b1;
        else                                  state <= next_state;
      end
    end
  end

  assign t_state = hlt_q ? 6'b0 : state;
  assign clr     = ~rst;
  assign hlt     = hlt_q;
  assign cp      = ctrl.cp;
  assign ep      = ctrl.ep;
  assign po      = ctrl.po;
  assign lm      = ctrl.lm;
  assign ce      = ctrl.ce;
  assign li      = ctrl.li;
  assign ei      = ctrl.ei;
  assign la      = ctrl.la;
  assign ea      = ctrl.ea;
  assign lb      = ctrl.lb;
  assign su      = ctrl.su;
  assign eu      = ctrl.eu;
  assign lo      = ctrl.lo;

endmodule
